// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, reads an 8-word block from main memory and writes it into the cache.
// Optional saturating fill counter enabled by defining CACHE_FILL_PERF_CNT_EN.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  fill_word_index,
  output logic        write_tag_array,
  output logic [15:0] fill_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  ret_cnt_q, ret_cnt_d;
  logic        ret_done_q, ret_done_d;

  // State, block base and request/return counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= 12'h000;
      issue_cnt_q <= 4'd0;
      ret_cnt_q   <= 3'd0;
      ret_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      ret_done_q  <= ret_done_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    ret_done_d       = ret_done_q;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = 16'h0000;
    write_data_array = 1'b0;
    fill_word_index  = 3'd0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        // Stall asserts in the detection cycle itself, before FILL is entered.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          state_d     = FILL;
          base_d      = miss_address[15:4];
          issue_cnt_d = 4'd0;
          ret_cnt_d   = 3'd0;
          ret_done_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < 4'd8) begin
          mem_en         = 1'b1;
          memory_address = {base_q, issue_cnt_q[2:0], 1'b0};
          issue_cnt_d    = issue_cnt_q + 4'd1;
        end else begin
          mem_en         = 1'b0;
          memory_address = 16'h0000;
        end
        // Returns are counted on their own; the done flag blocks a wrap into a 9th write.
        if (memory_data_valid && !ret_done_q) begin
          write_data_array = 1'b1;
          fill_word_index  = ret_cnt_q;
          if (ret_cnt_q == 3'd7) begin
            write_tag_array = 1'b1;
            ret_done_d      = 1'b1;
            state_d         = IDLE;
          end else begin
            ret_cnt_d = ret_cnt_q + 3'd1;
          end
        end else begin
          write_data_array = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] fill_count_q, fill_count_d;

  // Saturating count of completed fills
  always_comb begin
    if (write_tag_array && (fill_count_q != 16'hFFFF)) begin
      fill_count_d = fill_count_q + 16'd1;
    end else begin
      fill_count_d = fill_count_q;
    end
  end

  // Fill counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count_q <= 16'h0000;
    end else begin
      fill_count_q <= fill_count_d;
    end
  end

  assign fill_count = fill_count_q;
`else
  assign fill_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed scenarios plus randomized return spacing,
// compared cycle by cycle against a transaction-level model of a block fill.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word_index;
  logic        write_tag_array;
  logic [15:0] fill_count;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word_index   (fill_word_index),
    .write_tag_array   (write_tag_array),
    .fill_count        (fill_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: a fill is "in flight" with a block base, words requested and words received.
  bit         m_fill;
  int         m_base;
  int         m_issued;
  int         m_returned;
  int         m_fills;
  logic [3:0] pipe;      // 4-cycle memory: request history
  bit         use_mem;
  int         obs_busy, obs_wr, obs_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fill     = 1'b0;
    m_base     = 0;
    m_issued   = 0;
    m_returned = 0;
    m_fills    = 0;
    pipe       = 4'b0000;
  endtask

  task automatic clear_obs();
    obs_busy = 0;
    obs_wr   = 0;
    obs_tag  = 0;
  endtask

  function automatic int exp_count();
`ifdef CACHE_FILL_PERF_CNT_EN
    return m_fills;
`else
    return 0;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model at the edge.
  task automatic step(input logic miss, input logic [15:0] addr, input logic ext_valid);
    logic valid;
    bit   e_busy, e_men, e_wr, e_tag;
    int   e_addr;
    @(negedge clk);
    valid = use_mem ? pipe[3] : ext_valid;
    miss_detected     = miss;
    miss_address      = addr;
    memory_data_valid = valid;
    e_busy = m_fill || miss;
    e_men  = m_fill && (m_issued < 8);
    e_addr = e_men ? (m_base * 16 + m_issued * 2) : 0;
    e_wr   = m_fill && valid && (m_returned < 8);
    e_tag  = e_wr && (m_returned == 7);
    #1;
    check("fsm_busy", 32'(fsm_busy), 32'(e_busy));
    check("mem_en", 32'(mem_en), 32'(e_men));
    check("memory_address", 32'(memory_address), 32'(e_addr));
    check("write_data_array", 32'(write_data_array), 32'(e_wr));
    check("write_tag_array", 32'(write_tag_array), 32'(e_tag));
    check("fill_count", 32'(fill_count), 32'(exp_count()));
    if (e_wr) check("fill_word_index", 32'(fill_word_index), 32'(m_returned));
    obs_busy += 32'(fsm_busy);
    obs_wr   += 32'(write_data_array);
    obs_tag  += 32'(write_tag_array);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!m_fill) begin
        if (miss) begin
          m_fill     = 1'b1;
          m_base     = int'(addr) / 16;
          m_issued   = 0;
          m_returned = 0;
        end
      end else begin
        if (e_men) m_issued++;
        if (e_wr) m_returned++;
        if (e_tag) begin
          m_fill = 1'b0;
          if (m_fills < 65535) m_fills++;
        end
      end
      pipe = {pipe[2:0], e_men};
    end
  endtask

  // Continue the current fill with a fixed address on the bus until it completes.
  task automatic run_fill(input logic miss, input logic [15:0] addr, input string tag);
    int n = 0;
    while (m_fill && n < 60) begin
      step(miss, addr, 1'b0);
      n++;
    end
    check(tag, 32'(m_fill), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    memory_data_valid = 1'b0;
    use_mem = 1'b0;
    model_reset();
    clear_obs();

    // Held in reset: outputs idle, busy follows miss only
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h1236, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    check("reset_wr_count", 32'(obs_wr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Miss at 0x1236 with 4-cycle memory
    use_mem = 1'b1;
    clear_obs();
    step(1'b1, 16'h1236, 1'b0);
    run_fill(1'b0, 16'h1236, "fill1_timeout");
    check("fill1_busy_cycles", 32'(obs_busy), 32'd13);
    check("fill1_writes", 32'(obs_wr), 32'd8);
    check("fill1_tags", 32'(obs_tag), 32'd1);
    step(1'b0, 16'h0000, 1'b0);

    // Returns while idle are ignored
    use_mem = 1'b0;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      step(1'b0, 16'h0000, 1'b0);
    end
    check("idle_writes", 32'(obs_wr), 32'd0);
    check("idle_tags", 32'(obs_tag), 32'd0);

    // Back-to-back fills with miss held high
    use_mem = 1'b1;
    clear_obs();
    step(1'b1, 16'h0040, 1'b0);
    run_fill(1'b1, 16'h0080, "b2b_first_timeout");
    step(1'b1, 16'h0080, 1'b0);
    run_fill(1'b0, 16'h0080, "b2b_second_timeout");
    check("b2b_writes", 32'(obs_wr), 32'd16);
    check("b2b_tags", 32'(obs_tag), 32'd2);

    // Address changes mid-fill must not disturb the base
    step(1'b1, 16'h5550, 1'b0);
    run_fill(1'b0, 16'hABCD, "addr_change_timeout");

    // Asynchronous reset after 5 data writes
    step(1'b1, 16'h2468, 1'b0);
    for (int n = 0; n < 40 && m_returned < 5; n++) step(1'b0, 16'h2468, 1'b0);
    check("pre_reset_returned", 32'(m_returned), 32'd5);
    @(negedge clk);
    miss_detected = 1'b0;
    memory_data_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 32'(fsm_busy), 32'd0);
    check("async_mem_en", 32'(mem_en), 32'd0);
    check("async_addr", 32'(memory_address), 32'd0);
    check("async_wr", 32'(write_data_array), 32'd0);
    check("async_tag", 32'(write_tag_array), 32'd0);
    check("async_count", 32'(fill_count), 32'd0);
    model_reset();
    clear_obs();
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hFFF0, 1'b0);
    run_fill(1'b0, 16'hFFF0, "post_reset_timeout");
    check("post_reset_writes", 32'(obs_wr), 32'd8);
    check("post_reset_tags", 32'(obs_tag), 32'd1);

    // Randomized fills with irregular return spacing
    use_mem = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int gap;
      int n;
      clear_obs();
      step(1'b1, 16'($urandom), 1'b0);
      gap = int'($urandom_range(0, 3));
      n = 0;
      while (m_fill && n < 200) begin
        logic v;
        v = (gap == 0);
        if (v) gap = int'($urandom_range(0, 3));
        else gap--;
        step(1'($urandom), 16'($urandom), v);
        n++;
      end
      check("rand_timeout", 32'(m_fill), 32'd0);
      check("rand_writes", 32'(obs_wr), 32'd8);
      check("rand_tags", 32'(obs_tag), 32'd1);
      step(1'b0, 16'h0000, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
